stp_count_mod: RTL
==================

# stp_count_mod

Parametrised modulo counter stage for the stop-watch timer chain, generalising the fixed 0–23 hour counter to any modulus. It adds up/down counting, pause without clearing, parallel load, a terminal-count carry/borrow output for cascading seconds → minutes → hours, and an optional lap-capture register with a valid/ack handshake. One instance serves each field of the stop-watch: MOD=60 for seconds and minutes, MOD=24 for hours.

## Interface
Parameters:
- MOD, 24, counter modulus; count range 0..MOD-1; legal range 2..256
- WIDTH, 8, width of count, load and lap ports; must satisfy 2^WIDTH ≥ MOD

Ports:
- CLK  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on the CLK rising edge
- run  in  1  1 = counting enabled; 0 = pause, count holds its value
- clr  in  1  synchronous clear of count to 0; independent of run
- dir  in  1  0 = count up, 1 = count down
- tick  in  1  count strobe, one step per cycle high; driven by the lower stage's carry or by the 1 Hz enable
- load  in  1  parallel load of load_val
- load_val  in  WIDTH  load value
- count  out  WIDTH  current count, registered
- carry  out  1  terminal-count pulse, combinational: tick & run & no clr/load & (dir=0 ? count==MOD-1 : count==0)
- lap  in  1  capture request (STP_LAP_EN only)
- lap_ack  in  1  consumer has read lap_val (STP_LAP_EN only)
- lap_val  out  WIDTH  captured count (STP_LAP_EN only)
- lap_valid  out  1  lap_val holds an unread capture (STP_LAP_EN only)
- lap_ovf  out  1  sticky: a capture overwrote an unread one (STP_LAP_EN only)

## Operation
- Count update priority, highest first: rst_n low → count=0. clr → 0. load → load_val, saturated to MOD-1 if load_val ≥ MOD. tick & run → step. Otherwise hold.
- Up step: count==MOD-1 → 0, else count+1. Down step: count==0 → MOD-1, else count−1.
- Arithmetic is WIDTH-bit unsigned. The comparison to MOD-1 is exact; no intermediate value ever exceeds MOD-1.
- run=0 holds count. This replaces the old behaviour where stop cleared the counter. Clearing is now only through clr.
- carry is asserted only in the cycle in which the wrap occurs. It is suppressed when clr or load is active that cycle.
- Cascading: carry of stage N drives tick of stage N+1. All stages share run, dir and clr.
- Lap path (STP_LAP_EN):
  - lap captures the registered count seen before that edge's update, and sets lap_valid.
  - lap_ack with lap_valid=1 clears lap_valid on the next edge.
  - lap and lap_ack in the same cycle: the capture wins; lap_valid stays 1 and lap_ovf does not set.
  - lap while lap_valid=1 and no ack: lap_val is overwritten and lap_ovf sets.
  - lap_ovf clears only on clr or reset.
  - lap works regardless of run.

## Timing
- Reset values: count=0, lap_val=0, lap_valid=0, lap_ovf=0. carry=0 while rst_n is low.
- count latency: 1 cycle from a tick, clr or load edge.
- carry: 0-cycle, combinational from tick/run/dir/count. A full cascade ripples within one cycle, so seconds 59→0, minutes 59→0 and hours 23→0 all update on the same edge.
- clr or reset in mid-count takes effect on the next edge; lap_valid is unaffected by clr.
- dir change takes effect on the next tick. No glitch state exists because carry decodes the current dir.

## Configuration
- STP_LAP_EN defined: lap, lap_ack, lap_val, lap_valid and lap_ovf ports are present, along with the capture logic.
- STP_LAP_EN undefined: those ports and their registers are absent. Counter behaviour is identical in both builds.

## Structure
- Shared package stp_pkg holds:
  - constants STP_SEC_MOD=60, STP_MIN_MOD=60, STP_HR_MOD=24
  - a function returning the minimum WIDTH for a given MOD
  - the dir encoding localparams STP_DIR_UP=0 and STP_DIR_DOWN=1
- One sub-module, stp_lap_capture, parametrised by WIDTH. It owns lap_val, lap_valid and lap_ovf and is instantiated only under STP_LAP_EN.
- Counter and carry logic stay in stp_count_mod.

## Test plan
- MOD=24, run=1, dir=0, tick every cycle from reset → count steps 0,1,…,23,0. carry is high exactly in the cycle count=23, once per 24 ticks.
- MOD=60, dir=1, load_val=0 then ticks → 0→59→58. carry is high in the count=0 cycle. load_val=75 → count=59 (saturated).
- Three cascaded stages (60/60/24) loaded to 23:59:59, with one tick → all stages read 0:0:0 on the same edge.
- Pause: count=7, run=0 with tick high for 5 cycles → count stays 7 and carry=0. clr → count=0 next cycle.
- Priority: clr, load(5) and tick together → count=0. load(5) with tick → count=5 and carry=0.
- STP_LAP_EN: lap at count=12 → lap_val=12, lap_valid=1. A second lap at 15 without ack → lap_val=15, lap_ovf=1. lap_ack → lap_valid=0. clr → lap_ovf=0.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared constants and helpers for the stop-watch counter chain.
// Field moduli, direction encoding and a minimum-width helper.
package stp_pkg;

    localparam int STP_SEC_MOD = 60;
    localparam int STP_MIN_MOD = 60;
    localparam int STP_HR_MOD  = 24;

    localparam logic STP_DIR_UP   = 1'b0;
    localparam logic STP_DIR_DOWN = 1'b1;

    // Smallest count width able to hold 0..mod-1.
    function automatic int stp_width(input int mod);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= mod) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/stp_lap_capture.sv
// Lap capture register with valid/ack handshake and sticky overflow flag.
// Present only in builds that define STP_LAP_EN.
module stp_lap_capture #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_lap,
    input  logic             i_lap_ack,
    input  logic [WIDTH-1:0] i_count,
    output logic [WIDTH-1:0] o_lap_val,
    output logic             o_lap_valid,
    output logic             o_lap_ovf
);

    logic [WIDTH-1:0] r_lap_val;
    logic             r_lap_valid;
    logic             r_lap_ovf;
    logic             w_overwrite;

    // An ack arriving alongside a new capture retires the old value, so no overflow.
    assign w_overwrite = i_lap & r_lap_valid & ~i_lap_ack;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lap_val   <= '0;
            r_lap_valid <= 1'b0;
        end else if (i_lap) begin
            r_lap_val   <= i_count;
            r_lap_valid <= 1'b1;
        end else if (i_lap_ack) begin
            r_lap_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lap_ovf <= 1'b0;
        end else if (i_clr) begin
            r_lap_ovf <= 1'b0;
        end else if (w_overwrite) begin
            r_lap_ovf <= 1'b1;
        end
    end

    assign o_lap_val   = r_lap_val;
    assign o_lap_valid = r_lap_valid;
    assign o_lap_ovf   = r_lap_ovf;

endmodule

// File: rtl/stp_count_mod.sv
// Modulo-MOD up/down counter stage with pause, load and cascadable carry.
// Define STP_LAP_EN to add the lap-capture ports and register.
module stp_count_mod
    import stp_pkg::*;
#(
    parameter int MOD   = 24,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic             dir,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry
`ifdef STP_LAP_EN
    ,
    input  logic             lap,
    input  logic             lap_ack,
    output logic [WIDTH-1:0] lap_val,
    output logic             lap_valid,
    output logic             lap_ovf
`endif
);

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_down;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_sat;
    logic             w_at_term;
    logic             w_step_en;

    // Wraps are decoded explicitly so no intermediate value exceeds MOD-1.
    assign w_up       = (r_count == TERM) ? '0 : r_count + 1'b1;
    assign w_down     = (r_count == '0) ? TERM : r_count - 1'b1;
    assign w_step     = (dir == STP_DIR_DOWN) ? w_down : w_up;
    assign w_load_sat = ({1'b0, load_val} >= MOD_EXT) ? TERM : load_val;

    assign w_at_term  = (dir == STP_DIR_DOWN) ? (r_count == '0) : (r_count == TERM);
    assign w_step_en  = tick & run;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_sat;
        end else if (w_step_en) begin
            r_count <= w_step;
        end
    end

    // Combinational so a whole cascade wraps on a single edge.
    assign carry = rst_n & w_step_en & ~clr & ~load & w_at_term;
    assign count = r_count;

`ifdef STP_LAP_EN
    stp_lap_capture #(
        .WIDTH (WIDTH)
    ) u_lap_capture (
        .i_clk       (CLK),
        .i_rst_n     (rst_n),
        .i_clr       (clr),
        .i_lap       (lap),
        .i_lap_ack   (lap_ack),
        .i_count     (r_count),
        .o_lap_val   (lap_val),
        .o_lap_valid (lap_valid),
        .o_lap_ovf   (lap_ovf)
    );
`endif

endmodule
